seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter WIDTH, default 8, pattern word width in bits.
REQ-002 Parameter CNTW, default 4, width of the repeat field.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an active transfer.
REQ-007 data  input  WIDTH  pattern word; MSB transmitted first.
REQ-008 len  input  log2(WIDTH)+1  bits per pass; 0 or values above WIDTH mean WIDTH.
REQ-009 rpt  input  CNTW  extra passes after the first; total passes = rpt+1.
REQ-010 seq  output  1  serial pattern bit; registered.
REQ-011 valid  output  1  seq carries a pattern bit this cycle; registered.
REQ-012 busy  output  1  transfer in progress (LOAD or SHIFT); registered.
REQ-013 done  output  1  one-cycle completion pulse; registered.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SHIFT, DONE.
REQ-015 In IDLE, start=1 SHALL capture data, len and rpt into holding registers, and the FSM SHALL go to LOAD.
REQ-016 LOAD SHALL last exactly one cycle: it loads the shift register from the held data, clears the bit and pass counters, then goes to SHIFT.
REQ-017 Latency SHALL be fixed: with start sampled at edge N, the first bit appears on seq with valid=1 after edge N+2.
REQ-018 In SHIFT, each cycle SHALL present the shift-register MSB on seq with valid=1, shift left by one with zero fill, and increment the bit counter.
REQ-019 After the len-th bit of a pass, if the pass count is below rpt, the FSM SHALL reload the held data and continue in SHIFT with no gap cycle, so valid stays high.
REQ-020 After the len-th bit of the final pass, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, busy=0, valid=0, then return to IDLE.
REQ-022 Total valid cycles per transfer SHALL equal eff_len*(rpt+1), where eff_len is len after the 0/oversize mapping; the maximum is WIDTH*2^CNTW.
REQ-023 start SHALL be ignored while in LOAD, SHIFT or DONE; changes on data, len or rpt after capture SHALL NOT affect the active transfer.
REQ-024 abort=1 in LOAD or SHIFT SHALL send the FSM to IDLE at the next edge, with valid=0, busy=0 and no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-025 If abort and start are both 1 in IDLE, start SHALL win.
REQ-026 seq SHALL be 0 whenever valid=0.
REQ-027 Unreachable state encodings SHALL recover to IDLE on the next edge with all outputs 0.
REQ-028 Counters SHALL NOT wrap within a transfer: the bit counter is log2(WIDTH)+1 bits and the pass counter is CNTW bits, compared against rpt before increment.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE and set seq, valid, busy and done to 0.
REQ-030 rst=1 at a rising edge SHALL clear the shift register, counters and holding registers.
REQ-031 rst SHALL take priority over start and abort, including in the middle of a transfer.
REQ-032 The first start honoured after reset SHALL be sampled at the first edge at which rst=0.

Structure
REQ-033 The state encoding (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11) and the default WIDTH/CNTW constants SHALL reside in the shared package seq_pkg.
REQ-034 The left-shift register with parallel load SHALL be the single sub-module seq_tx_shreg (ports: clk, rst, load, shift, din, msb).
REQ-035 Next-state logic SHALL be combinational, with a default next-state assignment and no latches; all outputs SHALL be registered.

Verification
REQ-036 Basic: data=8'hB5, len=0, rpt=0, start pulse -> seq 1,0,1,1,0,1,0,1 on 8 consecutive valid cycles, then done=1 for 1 cycle.
REQ-037 Repeat: data=8'hC0, len=3, rpt=2 -> seq 110110110 on 9 gapless valid cycles, then one done pulse.
REQ-038 Abort: data=8'hFF, len=8, abort asserted on the 4th valid cycle -> valid and busy low at the next edge, no done pulse, FSM back in IDLE.
REQ-039 Ignored start: start pulsed with data=8'h00 during SHIFT of an 8'hAA transfer -> output stays 10101010 and exactly one done pulse occurs.
REQ-040 Mid-transfer reset: rst=1 for 1 cycle during SHIFT -> all outputs 0 after that edge; a new start (data=8'h81, len=8) then yields 10000001.
REQ-041 Max length: len=8, rpt=15 -> exactly 128 valid cycles and one done pulse; busy is high from the edge after start until DONE.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default sizing for the seq_tx pattern transmitter
package seq_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNTW_DEF = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;
endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg: left-shift register with parallel load and zero fill, MSB exposed
module seq_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] r_q;
  // load has priority over shift; zeros enter at the LSB
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else if (load) r_q <= din;
    else if (shift) r_q <= {r_q[WIDTH-2:0], 1'b0};
  end
  assign msb = r_q[WIDTH-1];
endmodule

// File: rtl/seq_tx.sv
// seq_tx: serialises a held pattern word MSB-first, len bits per pass, rpt+1 gapless passes
module seq_tx import seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       data,
  input  logic [$clog2(WIDTH):0] len,
  input  logic [CNTW-1:0]        rpt,
  output logic                   seq,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);
  localparam int LW = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0] L_MAX = LW'(WIDTH);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_data;
  logic [LW-1:0] r_len, r_bit, w_bit_inc;
  logic [CNTW-1:0] r_rpt, r_pass;
  logic w_load, w_shift, w_msb, w_last, w_more, w_valid;
  assign w_bit_inc = r_bit + LW'(1);
  assign w_last = w_bit_inc == r_len;
  assign w_more = r_pass < r_rpt;
  assign w_valid = r_state == SHIFT && !abort;
  seq_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .shift(w_shift),
    .din  (r_data),
    .msb  (w_msb)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and shift-register control; a pass boundary with passes left reloads instead of shifting
  always_comb begin
    w_next = IDLE;
    w_load = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: w_next = start ? LOAD : IDLE;
      LOAD: begin
        w_load = 1'b1;
        w_next = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        w_load = !abort && w_last && w_more;
        w_shift = !abort && !(w_last && w_more);
        w_next = abort ? IDLE : (w_last && !w_more) ? DONE : SHIFT;
      end
      default: w_next = IDLE;
    endcase
  end
  // capture request parameters in IDLE and track bit/pass progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_len <= '0;
      r_rpt <= '0;
      r_bit <= '0;
      r_pass <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_data <= data;
        r_len <= (len == '0 || len > L_MAX) ? L_MAX : len;
        r_rpt <= rpt;
      end
      if (r_state == LOAD) begin
        r_bit <= '0;
        r_pass <= '0;
      end else if (r_state == SHIFT) begin
        r_bit <= w_last ? '0 : w_bit_inc;
        r_pass <= r_pass + CNTW'(w_last && w_more);
      end
    end
  end
  // registered outputs lag the state by one cycle, so done follows the last valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      seq <= w_valid & w_msb;
      valid <= w_valid;
      busy <= w_next == LOAD || w_next == SHIFT || w_valid;
      done <= r_state == DONE;
    end
  end
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: randomized self-checking bench for seq_tx against a bit-queue reference model
module tb_seq_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] len = '0, rpt = '0;
  logic seq, valid, busy, done;
  int n_chk = 0, n_pass = 0;
  seq_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data(data),
    .len(len), .rpt(rpt), .seq(seq), .valid(valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic idle_chk(input string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_seq"}, 32'(seq), 0);
  endtask
  task automatic scramble();
    data = 8'($urandom);
    len = 4'($urandom);
    rpt = 4'($urandom);
  endtask
  // ab>0: abort during that valid cycle; ab<0: abort during DONE; ign: stray start with data 0 mid-transfer; ab_st: abort together with start
  task automatic xfer(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r, input int ab, input bit ign, input bit ab_st);
    bit q[$];
    int eff;
    eff = (l == 0 || l > 8) ? 8 : int'(l);
    for (int p = 0; p <= int'(r); p++)
      for (int i = 0; i < eff; i++) q.push_back(d[7-i]);
    data = d; len = l; rpt = r; start = 1'b1; abort = ab_st;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; scramble();
    check("load_busy", 32'(busy), 1);
    check("load_valid", 32'(valid), 0);
    @(negedge clk);
    scramble();
    check("lat_busy", 32'(busy), 1);
    check("lat_valid", 32'(valid), 0);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check("bit_valid", 32'(valid), 1);
      check($sformatf("bit%0d_seq", k), 32'(seq), 32'(q[k]));
      check("bit_busy", 32'(busy), 1);
      check("bit_done", 32'(done), 0);
      scramble();
      start = ign && k == 2;
      if (start) data = 8'h00;
      abort = (ab == k + 1) || (ab < 0 && k == q.size() - 1);
      if (ab == k + 1) begin
        @(negedge clk);
        abort = 1'b0;
        idle_chk("abort");
        @(negedge clk);
        idle_chk("abort_nodone");
        return;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("done_valid", 32'(valid), 0);
    check("done_busy", 32'(busy), 0);
    check("done_seq", 32'(seq), 0);
    @(negedge clk);
    idle_chk("post_done");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    xfer(8'hB5, 4'd0, 4'd0, 0, 1'b0, 1'b0);
    xfer(8'hC0, 4'd3, 4'd2, 0, 1'b0, 1'b0);
    xfer(8'hFF, 4'd8, 4'd0, 4, 1'b0, 1'b0);
    xfer(8'h3C, 4'd5, 4'd1, 0, 1'b0, 1'b0);
    xfer(8'hAA, 4'd8, 4'd0, 0, 1'b1, 1'b0);
    xfer(8'h96, 4'd12, 4'd1, 0, 1'b0, 1'b1);
    xfer(8'h5A, 4'd1, 4'd3, -1, 1'b0, 1'b0);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    idle_chk("idle_abort");
    data = 8'hAA; len = 4'd8; rpt = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_chk("mid_rst");
    rst = 1'b0;
    xfer(8'h81, 4'd8, 4'd0, 0, 1'b0, 1'b0);
    xfer(8'($urandom), 4'd8, 4'd15, 0, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      logic [3:0] l, r;
      int ab;
      l = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      xfer(8'($urandom), l, r, ab, 1'b0, 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
